// File: rtl/riscv_pkg.sv
// Shared definitions for the load/store path: Funct3 access encodings,
// load/store unit FSM states, and an alignment helper.
package riscv_pkg;

  // Funct3 access size/sign encodings (RV32I loads/stores).
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Load/store unit FSM states.
  typedef enum logic {
    IDLE      = 1'b0,
    RMW_WRITE = 1'b1
  } lsu_state_e;

  // True when the byte offset is not a multiple of the access size.
  // Byte accesses (and unknown encodings) are never misaligned here; the
  // illegal-encoding check is done separately by the caller.
  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3)
      F3_H, F3_HU: return offset[0];
      F3_W:        return |offset;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load lane selection and extension (purely combinational).
// Ports:
//   funct3_i  - access size/sign (B, H, W, BU, HU)
//   offset_i  - byte offset inside the word (little-endian lanes)
//   word_i    - full word read from data memory
//   data_o    - selected lane, sign- or zero-extended; word passed through
module load_extend
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3_i,
  input  logic [1:0]            offset_i,
  input  logic [DATA_WIDTH-1:0] word_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word_i[{offset_i, 3'b000} +: 8];
  assign half_sel = word_i[{offset_i[1], 4'b0000} +: 16];

  always_comb begin
    case (funct3_i)
      F3_B:    data_o = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      F3_BU:   data_o = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      F3_H:    data_o = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
      F3_HU:   data_o = {{(DATA_WIDTH-16){1'b0}}, half_sel};
      F3_W:    data_o = word_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the core and a word-addressed data memory with a
// combinational read port. Word stores and all loads complete in the request
// cycle; byte/half stores perform a read-modify-write: the old word is read
// and merged in the request cycle (core stalled), and written the next cycle.
// Ports:
//   clk, reset          - system clock; asynchronous active-high reset
//   Mem_Write_i         - core store request
//   Mem_Read_i          - core load request
//   Funct3_i            - access size/sign
//   Address_i           - core byte address
//   Write_Data_i        - store data, right-aligned
//   DM_Read_Data_i      - word read from data memory
//   DM_Mem_Write_o      - data-memory write enable
//   DM_Mem_Read_o       - data-memory read enable
//   DM_Address_o        - word-aligned memory address
//   DM_Write_Data_o     - full word to write
//   Read_Data_o         - extended load result
//   Stall_o             - core must hold PC and request inputs
//   Access_Error_o      - misaligned access or illegal request
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Mem_Write_i,
  input  logic                  Mem_Read_i,
  input  logic [2:0]            Funct3_i,
  input  logic [DATA_WIDTH-1:0] Address_i,
  input  logic [DATA_WIDTH-1:0] Write_Data_i,
  input  logic [DATA_WIDTH-1:0] DM_Read_Data_i,
  output logic                  DM_Mem_Write_o,
  output logic                  DM_Mem_Read_o,
  output logic [DATA_WIDTH-1:0] DM_Address_o,
  output logic [DATA_WIDTH-1:0] DM_Write_Data_o,
  output logic [DATA_WIDTH-1:0] Read_Data_o,
  output logic                  Stall_o,
  output logic                  Access_Error_o
);

  lsu_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] merge_q, merge_d;

  logic                  is_store;
  logic                  is_load;
  logic                  access_err;
  logic [4:0]            lane_shift;
  logic [DATA_WIDTH-1:0] lane_mask;
  logic [DATA_WIDTH-1:0] lane_data;
  logic [DATA_WIDTH-1:0] merged_word;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  dm_we;

  assign is_store = Mem_Write_i & ~Mem_Read_i;
  assign is_load  = Mem_Read_i & ~Mem_Write_i;

  // Request legality: simultaneous load+store, illegal encodings for the
  // direction, or an offset that is not a multiple of the access size.
  always_comb begin
    access_err = 1'b0;
    if (Mem_Write_i && Mem_Read_i) begin
      access_err = 1'b1;
    end else if (Mem_Write_i) begin
      access_err = !(Funct3_i inside {F3_B, F3_H, F3_W}) ||
                   misaligned(Funct3_i, Address_i[1:0]);
    end else if (Mem_Read_i) begin
      access_err = (Funct3_i inside {3'b011, 3'b110, 3'b111}) ||
                   misaligned(Funct3_i, Address_i[1:0]);
    end
  end

  // Sub-word store merge: replace the addressed lane of the old word.
  always_comb begin
    if (Funct3_i == F3_H) begin
      lane_shift = {Address_i[1], 4'b0000};
      lane_mask  = DATA_WIDTH'(16'hFFFF) << lane_shift;
      lane_data  = DATA_WIDTH'(Write_Data_i[15:0]) << lane_shift;
    end else begin
      lane_shift = {Address_i[1:0], 3'b000};
      lane_mask  = DATA_WIDTH'(8'hFF) << lane_shift;
      lane_data  = DATA_WIDTH'(Write_Data_i[7:0]) << lane_shift;
    end
    merged_word = (DM_Read_Data_i & ~lane_mask) | lane_data;
  end

  // NOTE: every signal assigned in this always_comb gets a default first so
  // that no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d         = state_q;
    merge_d         = merge_q;
    dm_we           = 1'b0;
    DM_Mem_Read_o   = 1'b0;
    DM_Write_Data_o = Write_Data_i;
    Stall_o         = 1'b0;
    case (state_q)
      IDLE: begin
        if (!access_err) begin
          if (is_store) begin
            if (Funct3_i == F3_W) begin
              dm_we = 1'b1;
            end else begin
              DM_Mem_Read_o = 1'b1;
              Stall_o       = 1'b1;
              merge_d       = merged_word;
              state_d       = RMW_WRITE;
            end
          end else if (is_load) begin
            DM_Mem_Read_o = 1'b1;
          end
        end
      end
      RMW_WRITE: begin
        // The core holds its request inputs through the stall, so the
        // address still refers to the word being merged.
        dm_we           = 1'b1;
        DM_Write_Data_o = merge_q;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together from values sampled before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      merge_q <= '0;
    end else begin
      state_q <= state_d;
      merge_q <= merge_d;
    end
  end

  load_extend #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_load_extend (
    .funct3_i (Funct3_i),
    .offset_i (Address_i[1:0]),
    .word_i   (DM_Read_Data_i),
    .data_o   (load_data)
  );

  // A pending merge write must never reach memory while reset is asserted.
  assign DM_Mem_Write_o = dm_we & ~reset;
  assign DM_Address_o   = {Address_i[DATA_WIDTH-1:2], 2'b00};
  assign Read_Data_o    = (is_load && !access_err) ? load_data : '0;
  assign Access_Error_o = access_err;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Mem_Write_i, Mem_Read_i;
  logic [2:0]  Funct3_i;
  logic [31:0] Address_i, Write_Data_i, DM_Read_Data_i;
  logic        DM_Mem_Write_o, DM_Mem_Read_o, Stall_o, Access_Error_o;
  logic [31:0] DM_Address_o, DM_Write_Data_o, Read_Data_o;

  int tests = 0;
  int fails = 0;

  // Data memory: 16 words at 0x10010000, combinational read.
  logic [31:0] dm [16] = '{default: 32'h0};
  // Reference model: byte-addressed shadow of the same 64 bytes.
  logic [7:0]  rmem [64] = '{default: 8'h0};

  always #5 clk = ~clk;

  assign DM_Read_Data_i = dm[DM_Address_o[5:2]];

  always @(posedge clk)
    if (DM_Mem_Write_o) dm[DM_Address_o[5:2]] <= DM_Write_Data_o;

  load_store_unit #(.DATA_WIDTH(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .Mem_Write_i     (Mem_Write_i),
    .Mem_Read_i      (Mem_Read_i),
    .Funct3_i        (Funct3_i),
    .Address_i       (Address_i),
    .Write_Data_i    (Write_Data_i),
    .DM_Read_Data_i  (DM_Read_Data_i),
    .DM_Mem_Write_o  (DM_Mem_Write_o),
    .DM_Mem_Read_o   (DM_Mem_Read_o),
    .DM_Address_o    (DM_Address_o),
    .DM_Write_Data_o (DM_Write_Data_o),
    .Read_Data_o     (Read_Data_o),
    .Stall_o         (Stall_o),
    .Access_Error_o  (Access_Error_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic ref_err(input logic w, input logic r,
                                   input logic [2:0] f3, input logic [31:0] a);
    int unsigned size;
    if (w && r) return 1'b1;
    if (!w && !r) return 1'b0;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    return 1'b1;
    endcase
    if (w && f3[2]) return 1'b1;  // no unsigned stores
    return (a % size) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    int unsigned off;
    int unsigned v;
    off = {26'b0, a[5:0]};
    case (f3)
      3'd0: begin v = {24'b0, rmem[off]}; if (v >= 128) v = v - 256; end
      3'd4: v = {24'b0, rmem[off]};
      3'd1: begin v = {16'b0, rmem[off+1], rmem[off]}; if (v >= 32768) v = v - 65536; end
      3'd5: v = {16'b0, rmem[off+1], rmem[off]};
      default: v = {rmem[off+3], rmem[off+2], rmem[off+1], rmem[off]};
    endcase
    return v;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int unsigned base;
    base = {26'b0, a[5:2], 2'b00};
    return {rmem[base+3], rmem[base+2], rmem[base+1], rmem[base]};
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int unsigned off;
    int n;
    off = {26'b0, a[5:0]};
    n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    for (int i = 0; i < n; i++) rmem[off + i] = 8'(d >> (8 * i));
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic w, input logic r, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    Mem_Write_i  = w;
    Mem_Read_i   = r;
    Funct3_i     = f3;
    Address_i    = a;
    Write_Data_i = d;
  endtask

  // One request, called just after a rising edge; returns just after the
  // edge that completes it, with inputs idle.
  task automatic do_op(input logic w, input logic r, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    logic err, st, ld, rmw;
    logic [31:0] exp_rd;
    err    = ref_err(w, r, f3, a);
    st     = w && !r && !err;
    ld     = r && !w && !err;
    rmw    = st && (f3 != 3'd2);
    exp_rd = ld ? ref_load(f3, a) : 32'h0;
    if (st) ref_store(f3, a, d);
    drive(w, r, f3, a, d);
    @(negedge clk);
    check("dm_addr", DM_Address_o, {a[31:2], 2'b00});
    check1("access_err", Access_Error_o, err);
    check("read_data", Read_Data_o, exp_rd);
    if (rmw) begin
      check1("rmw_stall", Stall_o, 1'b1);
      check1("rmw_read_en", DM_Mem_Read_o, 1'b1);
      check1("rmw_no_early_write", DM_Mem_Write_o, 1'b0);
      @(negedge clk);
      check1("rmw_write_en", DM_Mem_Write_o, 1'b1);
      check1("rmw_stall_released", Stall_o, 1'b0);
      check1("rmw_read_off", DM_Mem_Read_o, 1'b0);
      check("rmw_wdata", DM_Write_Data_o, ref_word(a));
    end else begin
      check1("stall", Stall_o, 1'b0);
      check1("write_en", DM_Mem_Write_o, st);
      check1("read_en", DM_Mem_Read_o, ld);
      if (st) check("sw_wdata", DM_Write_Data_o, d);
    end
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    check("mem_word", dm[a[5:2]], ref_word(a));
  endtask

  task automatic load_const(input string tag, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] exp);
    drive(1'b0, 1'b1, f3, a, 32'h0);
    @(negedge clk);
    check(tag, Read_Data_o, exp);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [2:0]  f3;
    logic [31:0] a, d;
    int          kind;

    reset = 1'b1;
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    #2;
    check1("rst_idle_we", DM_Mem_Write_o, 1'b0);
    check1("rst_idle_re", DM_Mem_Read_o, 1'b0);
    check1("rst_idle_stall", Stall_o, 1'b0);
    check1("rst_idle_err", Access_Error_o, 1'b0);
    drive(1'b1, 1'b0, 3'd2, 32'h10010004, 32'h12345678);
    #1;
    check1("rst_sw_we_forced_low", DM_Mem_Write_o, 1'b0);
    check1("rst_sw_err", Access_Error_o, 1'b0);
    drive(1'b1, 1'b0, 3'd0, 32'h10010005, 32'h12);
    #1;
    check1("rst_sb_stall", Stall_o, 1'b1);
    check1("rst_sb_re", DM_Mem_Read_o, 1'b1);
    check1("rst_sb_we", DM_Mem_Write_o, 1'b0);
    #4;
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Word store with immediate write.
    do_op(1'b1, 1'b0, 3'd2, 32'h10010004, 32'hDEADBEEF);

    // Byte store read-modify-write.
    do_op(1'b1, 1'b0, 3'd2, 32'h10010008, 32'h11223344);
    do_op(1'b1, 1'b0, 3'd0, 32'h1001000A, 32'h000000AB);
    check("sb_merged_word", dm[2], 32'h11AB3344);

    // Load lane selection and extension.
    do_op(1'b1, 1'b0, 3'd2, 32'h10010020, 32'h8000FF7F);
    load_const("lb_off0", 3'd0, 32'h10010020, 32'h0000007F);
    load_const("lb_off1", 3'd0, 32'h10010021, 32'hFFFFFFFF);
    load_const("lhu_off2", 3'd5, 32'h10010022, 32'h00008000);
    load_const("lh_off2", 3'd1, 32'h10010022, 32'hFFFF8000);

    // Misaligned half store, illegal encodings, both requests, no request.
    do_op(1'b1, 1'b0, 3'd1, 32'h10010003, 32'h0000BEEF);
    do_op(1'b1, 1'b0, 3'd4, 32'h10010008, 32'h000000CC);
    do_op(1'b0, 1'b1, 3'd3, 32'h10010008, 32'h0);
    do_op(1'b0, 1'b1, 3'd2, 32'h1001000A, 32'h0);
    do_op(1'b1, 1'b1, 3'd2, 32'h10010008, 32'h55555555);
    do_op(1'b0, 1'b0, 3'd2, 32'h10010008, 32'h0);

    // Reset while the merge write is pending drops that write.
    do_op(1'b1, 1'b0, 3'd2, 32'h10010030, 32'h01020304);
    drive(1'b1, 1'b0, 3'd0, 32'h10010031, 32'h000000EE);
    @(negedge clk);
    check1("pre_rst_stall", Stall_o, 1'b1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(negedge clk);
    check1("rst_in_rmw_we", DM_Mem_Write_o, 1'b0);
    check1("rst_in_rmw_stall", Stall_o, 1'b1);
    #1;
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mem_unchanged", dm[12], 32'h01020304);
    @(negedge clk);
    check1("post_rst_no_write", DM_Mem_Write_o, 1'b0);
    @(posedge clk);
    #1;
    do_op(1'b1, 1'b0, 3'd2, 32'h10010034, 32'hA5A5A5A5);

    // Back-to-back half store then word store to the same word.
    do_op(1'b1, 1'b0, 3'd1, 32'h10010010, 32'h00005555);
    do_op(1'b1, 1'b0, 3'd2, 32'h10010010, 32'hCAFEF00D);
    check("b2b_final_word", dm[4], 32'hCAFEF00D);

    // Random traffic against the byte-level model.
    for (int i = 0; i < 150; i++) begin
      kind = int'($urandom_range(9));
      f3   = 3'($urandom_range(7));
      a    = 32'h10010000 + 32'($urandom_range(63));
      if ($urandom_range(1) == 1) a[1:0] = 2'b00;
      d    = $urandom;
      case (kind)
        0:             do_op(1'b0, 1'b0, f3, a, d);
        1:             do_op(1'b1, 1'b1, f3, a, d);
        2, 3, 4, 5:    do_op(1'b1, 1'b0, f3, a, d);
        default:       do_op(1'b0, 1'b1, f3, a, d);
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
